// File: rtl/sc_lanescroll_pkg.sv
// Shared encodings for the lane scroller: FSM state codes and per-lane shift-select codes.
package sc_lanescroll_pkg;

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_START = 4'd1;
    localparam logic [3:0] ST_IDLE  = 4'd2;
    localparam logic [3:0] ST_INIT  = 4'd3;
    localparam logic [3:0] ST_LOAD  = 4'd4;
    localparam logic [3:0] ST_REL_S = 4'd5;
    localparam logic [3:0] ST_RUN   = 4'd6;
    localparam logic [3:0] ST_REL_P = 4'd7;
    localparam logic [3:0] ST_PAUSE = 4'd8;
    localparam logic [3:0] ST_REL_R = 4'd9;

    localparam logic [1:0] LC_HOLD = 2'b11;
    localparam logic [1:0] LC_SHR  = 2'b10;
    localparam logic [1:0] LC_SHL  = 2'b01;
    localparam logic [1:0] LC_LOAD = 2'b00;

endpackage

// File: rtl/sc_lanescroll_lanectr.sv
// One lane's tick down-counter: strobes when it expires on a tick, then reloads its latched period.
module sc_lanescroll_lanectr #(
    parameter int PER_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_tick,
    input  logic [PER_W-1:0] i_period,
    input  logic             i_dir,
    output logic             o_strobe,
    output logic             o_dir
);

    localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

    logic [PER_W-1:0] r_per;
    logic [PER_W-1:0] r_cnt;
    logic             r_dir;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_per <= '0;
            r_cnt <= '0;
            r_dir <= 1'b0;
        end else if (i_load) begin
            r_per <= i_period;
            r_cnt <= i_period;
            r_dir <= i_dir;
        end else if (i_tick) begin
            r_cnt <= (r_cnt == '0) ? r_per : r_cnt - CNT_ONE;
        end
    end

    assign o_strobe = i_tick && (r_cnt == '0);
    assign o_dir    = r_dir;

endmodule

// File: rtl/sc_lane_scroller_fsm.sv
// Multi-lane background sequencer: button FSM, shared tick prescaler and per-lane scroll counters.
module sc_lane_scroller_fsm
    import sc_lanescroll_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int PER_W    = 4,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                   SC_LANESCROLL_CLOCK_50,
    input  logic                   SC_LANESCROLL_RESET_InLow,
    input  logic                   SC_LANESCROLL_startButton_InLow,
    input  logic                   SC_LANESCROLL_pauseButton_InLow,
    input  logic [LANES*PER_W-1:0] SC_LANESCROLL_period_In,
    input  logic [LANES-1:0]       SC_LANESCROLL_dir_In,
    output logic                   SC_LANESCROLL_clear_OutLow,
    output logic                   SC_LANESCROLL_load_OutLow,
    output logic [2*LANES-1:0]     SC_LANESCROLL_shiftselection_Out,
    output logic                   SC_LANESCROLL_running_Out,
    output logic                   SC_LANESCROLL_tick_Out
);

    localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic             w_load;
    logic [LANES-1:0] w_strobe;
    logic [LANES-1:0] w_dir;

    wire w_start = ~SC_LANESCROLL_startButton_InLow;
    wire w_pause = ~SC_LANESCROLL_pauseButton_InLow;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET: w_next = ST_START;
            ST_START: w_next = ST_IDLE;
            ST_IDLE:  if (w_start) w_next = ST_INIT;
            ST_INIT:  w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_REL_S;
            ST_REL_S: if (!w_start) w_next = ST_RUN;
            ST_RUN: begin
                if (w_start)      w_next = ST_INIT;
                else if (w_pause) w_next = ST_REL_P;
            end
            ST_REL_P: if (!w_pause) w_next = ST_PAUSE;
            ST_PAUSE: begin
                if (w_start)      w_next = ST_INIT;
                else if (w_pause) w_next = ST_REL_R;
            end
            ST_REL_R: if (!w_pause) w_next = ST_RUN;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_LANESCROLL_CLOCK_50 or negedge SC_LANESCROLL_RESET_InLow) begin
        if (!SC_LANESCROLL_RESET_InLow) r_state <= ST_RESET;
        else                            r_state <= w_next;
    end

    // Prescaler only advances in RUN so pause freezes the tick phase exactly.
    always_ff @(posedge SC_LANESCROLL_CLOCK_50 or negedge SC_LANESCROLL_RESET_InLow) begin
        if (!SC_LANESCROLL_RESET_InLow)  r_pre <= '0;
        else if (r_state == ST_LOAD)     r_pre <= '0;
        else if (r_state == ST_RUN)      r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + PRE_ONE;
    end

    assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_MAX);
    assign w_load = (r_state == ST_LOAD);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sc_lanescroll_lanectr #(.PER_W(PER_W)) u_ctr (
            .i_clk    (SC_LANESCROLL_CLOCK_50),
            .i_rst_n  (SC_LANESCROLL_RESET_InLow),
            .i_load   (w_load),
            .i_tick   (w_tick),
            .i_period (SC_LANESCROLL_period_In[g*PER_W +: PER_W]),
            .i_dir    (SC_LANESCROLL_dir_In[g]),
            .o_strobe (w_strobe[g]),
            .o_dir    (w_dir[g])
        );
    end

    always_comb begin
        SC_LANESCROLL_clear_OutLow       = 1'b1;
        SC_LANESCROLL_load_OutLow        = 1'b1;
        SC_LANESCROLL_shiftselection_Out = {LANES{LC_HOLD}};
        case (r_state)
            ST_RESET, ST_INIT: SC_LANESCROLL_clear_OutLow = 1'b0;
            ST_LOAD: begin
                SC_LANESCROLL_load_OutLow        = 1'b0;
                SC_LANESCROLL_shiftselection_Out = {LANES{LC_LOAD}};
            end
            ST_RUN: begin
                for (int i = 0; i < LANES; i++)
                    if (w_strobe[i])
                        SC_LANESCROLL_shiftselection_Out[2*i +: 2] = w_dir[i] ? LC_SHL : LC_SHR;
            end
            default: ;
        endcase
    end

    assign SC_LANESCROLL_running_Out = (r_state == ST_RUN);
    assign SC_LANESCROLL_tick_Out    = w_tick;

endmodule

// File: doc/sc_lane_scroller_fsm.md
# sc_lane_scroller_fsm

Parametrised multi-lane background sequencer for the Frogger playfield. It drives the clear, load and per-lane shift-select controls of `LANES` background shift registers (cars, logs). Each lane scrolls at its own programmable period and direction, timed from a shared tick prescaler. Start and pause buttons are debounced, active-low level inputs; the block sits between the button conditioning logic and the background register bank.

## Interface
Parameters:
- `LANES`, 4, number of independently scrolled lanes (1..16)
- `PER_W`, 4, width of each lane's period field, in ticks
- `TICK_DIV`, 25_000_000, clock cycles per scroll tick (≥2)

Ports:
- `SC_LANESCROLL_CLOCK_50`  in  1  system clock
- `SC_LANESCROLL_RESET_InLow`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `SC_LANESCROLL_startButton_InLow`  in  1  start/restart request, 0 = pressed
- `SC_LANESCROLL_pauseButton_InLow`  in  1  pause toggle, 0 = pressed
- `SC_LANESCROLL_period_In`  in  LANES*PER_W  lane i period in bits [i*PER_W +: PER_W]; sampled in LOAD
- `SC_LANESCROLL_dir_In`  in  LANES  lane i direction (0 = right, 1 = left); sampled in LOAD
- `SC_LANESCROLL_clear_OutLow`  out  1  clear background registers
- `SC_LANESCROLL_load_OutLow`  out  1  parallel-load background registers
- `SC_LANESCROLL_shiftselection_Out`  out  2*LANES  lane i code in [2i+1:2i]: 11 hold, 10 shift right, 01 shift left, 00 load
- `SC_LANESCROLL_running_Out`  out  1  high in RUN only
- `SC_LANESCROLL_tick_Out`  out  1  one-cycle tick pulse, RUN only

## Operation
- Outputs are a combinational decode of the state register and lane counters.
- States:
  - RESET → START → IDLE, unconditional.
  - IDLE: start=0 → INIT; otherwise stay.
  - INIT → LOAD.
  - LOAD → REL_S.
  - REL_S: stay while start=0, else → RUN.
  - RUN: start=0 → INIT (priority); else pause=0 → REL_P; else stay.
  - REL_P: stay while pause=0, else → PAUSE.
  - PAUSE: start=0 → INIT; pause=0 → REL_R; else stay.
  - REL_R: stay while pause=0, else → RUN.
  - Unused encodings → IDLE.
- Per-state outputs:
  - RESET and INIT: clear=0.
  - LOAD: load=0 and all lane codes 00; latches period/dir into internal registers; every lane counter := its period; prescaler := 0.
  - All other states: clear=1, load=1, lane codes 11, except in RUN as below.
- Prescaler (width ceil(log2 TICK_DIV)):
  - Counts only in RUN; holds its value in PAUSE and REL_*.
  - On the cycle it equals TICK_DIV-1: tick=1, and it wraps to 0 next cycle.
- On a tick cycle, for each lane:
  - Counter == 0: lane code = 10/01 per latched dir for that cycle only; counter reloads to period.
  - Otherwise: counter decrements.
  - A lane shifts every (period+1) ticks. Period 0 shifts on every tick; all-ones is the maximum. Multiple lanes expiring on the same tick all shift in the same cycle.
- Changing period_In/dir_In outside LOAD has no effect until the next start.
- Reset asserted mid-operation: immediate return to RESET and all outputs at reset values; nothing is retained.

## Timing
- Reset values (while reset is low):
  - State RESET
  - clear_OutLow=0, load_OutLow=1
  - all lane codes 11
  - running=0, tick=0
  - prescaler and lane counters 0; latched period/dir 0
- Start press seen in IDLE: INIT next cycle (clear low 1 cycle), then LOAD (load low 1 cycle), then REL_S.
- RUN is entered on the cycle after start is released.
- First tick: TICK_DIV cycles after RUN entry. A lane with period p first shifts on tick p+1.
- Pause freezes the prescaler and counters exactly. After resume, the tick phase continues from the frozen value.
- Start pressed in RUN or PAUSE restarts the game through INIT/LOAD with one cycle per state.

## Structure
- Shared package `sc_lanescroll_pkg`:
  - state encoding localparams (4-bit)
  - lane code constants HOLD=2'b11, SHR=2'b10, SHL=2'b01, LOAD=2'b00
- Sub-module `sc_lanescroll_lanectr`: one per lane, generated `LANES` times. Contains the PER_W down-counter with reload, a shift-strobe output and the latched dir bit. Top level holds the FSM and prescaler.

## Test plan
Run all scenarios with TICK_DIV=4, LANES=4, PER_W=4.
1. Reset low then high, no buttons → clear low only in RESET, then IDLE; all codes 11; running=0.
2. Start pulse of 3 cycles, periods {0,1,2,3}, dir=4'b0101 → clear low 1 cycle, load low 1 cycle with codes 00; running high on the cycle after release.
3. Continue in RUN for 48 cycles → tick every 4 cycles.
   - Lane0 shifts left every tick.
   - Lane1 shifts right every 2nd tick.
   - Lane2 shifts left every 3rd tick.
   - Lane3 shifts right every 4th tick.
   - On tick 12, all four lanes shift in the same cycle.
4. Pause pressed 2 cycles after a tick, held 5 cycles, RUN kept 20 cycles, pressed again → no shifts or ticks while paused; after resume, the next tick arrives 2 cycles later.
5. Start pressed while in PAUSE → INIT/LOAD re-executed; counters reloaded from the new period_In={1,1,1,1}.
6. Reset asserted mid-tick in RUN → outputs at reset values within the same cycle; no further shifts until a new start.
